// File: rtl/membus_pkg.sv
// membus_adapter shared types and default widths.
// Imported by membus_adapter and membus_timeout.
package membus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } membus_state_t;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/membus_timeout.sv
// Bus-cycle watchdog for membus_adapter.
// Built only when MEMBUS_TIMEOUT_EN is defined.
module membus_timeout
  import membus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires in the cycle whose edge would bring the count to the limit.
  assign expired = count_en &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/membus_adapter.sv
// Controller-to-Wishbone classic bus adapter.
// Optional bus timeout: define MEMBUS_TIMEOUT_EN.
module membus_adapter
  import membus_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_req,
  input  logic                write_req,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   wdata_in,
  input  logic [DATA_W/8-1:0] sel_in,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rdata_out,
  output logic                err,
  output logic                bus_cyc,
  output logic                bus_stb,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_adr,
  output logic [DATA_W-1:0]   bus_dat_o,
  output logic [DATA_W/8-1:0] bus_sel,
  input  logic [DATA_W-1:0]   bus_dat_i,
  input  logic                bus_ack
);

  membus_state_t state_q, state_d;

  logic                we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W/8-1:0] sel_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                expired;
  logic                in_bus;
  logic                accept;

  assign in_bus = (state_q == BUS);
  assign accept = (state_q == IDLE) &&
                  (read_req || write_req);

`ifdef MEMBUS_TIMEOUT_EN
  membus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_bus),
    .count_en(in_bus && !bus_ack),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (read_req || write_req) state_d = BUS;
      BUS:  if (bus_ack || expired) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= in_bus && expired;
      // Write wins when both requests arrive together.
      if (accept) begin
        we_q  <= write_req;
        adr_q <= addr_in;
        dat_q <= wdata_in;
        sel_q <= sel_in;
      end
      if (in_bus && bus_ack && !we_q) begin
        rdata_q <= bus_dat_i;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign rdata_out = rdata_q;

  assign bus_cyc   = in_bus;
  assign bus_stb   = in_bus;
  assign bus_we    = in_bus && we_q;
  assign bus_adr   = in_bus ? adr_q : '0;
  assign bus_dat_o = (in_bus && we_q) ? dat_q : '0;
  assign bus_sel   = in_bus ? sel_q : '0;

endmodule

// File: tb/tb_membus_adapter.sv
// Directed scoreboard bench for membus_adapter.
// Timeout steps run when MEMBUS_TIMEOUT_EN is defined.
module tb_membus_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_req, write_req;
  logic [31:0] addr_in, wdata_in;
  logic [3:0]  sel_in;
  logic        busy, done, err;
  logic [31:0] rdata_out;
  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_adr, bus_dat_o, bus_dat_i;
  logic [3:0]  bus_sel;
  logic        bus_ack;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_rd;

  membus_adapter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .read_req(read_req), .write_req(write_req),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .sel_in(sel_in), .busy(busy), .done(done),
    .rdata_out(rdata_out), .err(err),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb),
    .bus_we(bus_we), .bus_adr(bus_adr),
    .bus_dat_o(bus_dat_o), .bus_sel(bus_sel),
    .bus_dat_i(bus_dat_i), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rd,
                      input logic e);
    exp_t x;
    x.rdata = rd;
    x.err   = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("extra_done", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_rdata", 64'(rdata_out), 64'(x.rdata));
        chk("sb_err", 64'(err), 64'(x.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    read_req = 0; write_req = 0;
    addr_in = 0; wdata_in = 0; sel_in = 0;
    bus_dat_i = 0; bus_ack = 0;
    last_rd = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_cyc", 64'(bus_cyc), 0);
    chk("rst_rdata", 64'(rdata_out), 0);
    chk("rst_adr", 64'(bus_adr), 0);

    // stray ack in IDLE
    bus_ack = 1;
    tick(); tick();
    chk("idle_ack_busy", 64'(busy), 0);
    bus_ack = 0;

    // zero-wait read
    read_req = 1; addr_in = 32'h0000_1004;
    push(32'hDEAD_BEEF, 0);
    last_rd = 32'hDEAD_BEEF;
    tick();
    read_req = 0;
    chk("rd_busy", 64'(busy), 1);
    chk("rd_cyc", 64'({bus_cyc, bus_stb}), 3);
    chk("rd_we", 64'(bus_we), 0);
    chk("rd_adr", 64'(bus_adr), 64'h1004);
    chk("rd_dato", 64'(bus_dat_o), 0);
    bus_ack = 1; bus_dat_i = 32'hDEAD_BEEF;
    tick();
    read_req = 1; addr_in = 32'h0000_9999;
    chk("rd_done", 64'(done), 1);
    chk("rd_done_cyc", 64'(bus_cyc), 0);
    chk("rd_rdata", 64'(rdata_out), 64'hDEAD_BEEF);
    tick();
    read_req = 0; bus_ack = 0; bus_dat_i = 0;
    chk("rd_idle", 64'({busy, done}), 0);
    tick();
    chk("done_req_ignored", 64'(busy), 0);

    // wait-state write with ignored inputs
    write_req = 1; addr_in = 32'h2000;
    wdata_in = 32'h1234_5678; sel_in = 4'b0011;
    push(last_rd, 0);
    tick();
    write_req = 0;
    for (int i = 0; i < 4; i++) begin
      read_req = i[0];
      addr_in = 32'hFFFF_0000 + i;
      wdata_in = 32'h0;
      chk("wr_we", 64'(bus_we), 1);
      chk("wr_adr", 64'(bus_adr), 64'h2000);
      chk("wr_dato", 64'(bus_dat_o), 64'h1234_5678);
      chk("wr_sel", 64'(bus_sel), 64'h3);
      chk("wr_done_lo", 64'(done), 0);
      if (i == 3) begin
        bus_ack = 1; bus_dat_i = 32'h0BAD_0BAD;
      end
      tick();
    end
    read_req = 0; bus_ack = 0;
    chk("wr_done", 64'(done), 1);
    chk("wr_rdata_kept", 64'(rdata_out), 64'(last_rd));
    tick();
    chk("wr_idle", 64'(busy), 0);

    // simultaneous requests: write wins
    read_req = 1; write_req = 1;
    addr_in = 32'h3000; wdata_in = 32'hA5A5_A5A5;
    sel_in = 4'hF;
    push(last_rd, 0);
    tick();
    read_req = 0; write_req = 0;
    chk("both_we", 64'(bus_we), 1);
    chk("both_dato", 64'(bus_dat_o), 64'hA5A5_A5A5);
    bus_ack = 1; bus_dat_i = 32'h7777_7777;
    tick();
    bus_ack = 0;
    tick();
    chk("both_rdata_kept", 64'(rdata_out), 64'(last_rd));
    tick();
    chk("both_one_txn", 64'(busy), 0);

    // reset mid-BUS drops the cycle
    read_req = 1; addr_in = 32'h4000;
    tick();
    read_req = 0;
    chk("mid_cyc", 64'(bus_cyc), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cyc", 64'(bus_cyc), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_adr", 64'(bus_adr), 0);
    chk("arst_rdata", 64'(rdata_out), 0);
    #1 rst = 1'b0;
    last_rd = 0;
    tick();
    chk("post_rst_idle", 64'(busy), 0);

    read_req = 1; addr_in = 32'h5008;
    push(32'hCAFE_0001, 0);
    last_rd = 32'hCAFE_0001;
    tick();
    read_req = 0;
    chk("fresh_adr", 64'(bus_adr), 64'h5008);
    bus_ack = 1; bus_dat_i = 32'hCAFE_0001;
    tick();
    bus_ack = 0;
    chk("fresh_rdata", 64'(rdata_out), 64'hCAFE_0001);
    tick();

`ifdef MEMBUS_TIMEOUT_EN
    write_req = 1; addr_in = 32'h6000;
    push(last_rd, 1);
    tick();
    write_req = 0;
    for (int i = 0; i < 8; i++) begin
      chk("to_in_bus", 64'(bus_cyc), 1);
      tick();
    end
    chk("to_done_err", 64'({done, err}), 3);
    chk("to_rdata_kept", 64'(rdata_out), 64'(last_rd));
    tick();
    chk("to_idle", 64'({busy, err}), 0);

    read_req = 1; addr_in = 32'h7000;
    push(32'h5555_5555, 0);
    last_rd = 32'h5555_5555;
    tick();
    read_req = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        bus_ack = 1; bus_dat_i = 32'h5555_5555;
      end
      tick();
    end
    bus_ack = 0;
    chk("ack_wins", 64'({done, err}), 2);
    tick();
`endif

    tick();
    chk("sb_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
